// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: load-type codes and write-back FSM states.
package mem_wb_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5,
    LOAD_LWL  = 3'd6,
    LOAD_LWR  = 3'd7
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HAVE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Combinational load-data formatter: byte/half extraction, extension and LWL/LWR merge.
// Kept standalone so the forwarding path can reuse it.
module load_formatter
  import mem_wb_stage_pkg::*;
(
  input  load_type_e          load_type,
  input  logic [1:0]          off,
  input  logic [DATA_W-1:0]   m,
  input  logic [DATA_W-1:0]   rt,
  output logic [DATA_W-1:0]   data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = m[7:0];
    case (off)
      2'd0: byte_sel = m[7:0];
      2'd1: byte_sel = m[15:8];
      2'd2: byte_sel = m[23:16];
      2'd3: byte_sel = m[31:24];
      default: byte_sel = m[7:0];
    endcase
    // Halfword alignment is checked upstream, so only off[1] matters.
    half_sel = off[1] ? m[31:16] : m[15:0];
  end

  always_comb begin
    data = m;
    case (load_type)
      LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {24'd0, byte_sel};
      LOAD_LH:  data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: data = {16'd0, half_sel};
      LOAD_LW:  data = m;
      LOAD_LWL: begin
        case (off)
          2'd0: data = {m[7:0],  rt[23:0]};
          2'd1: data = {m[15:0], rt[15:0]};
          2'd2: data = {m[23:0], rt[7:0]};
          default: data = m;
        endcase
      end
      LOAD_LWR: begin
        case (off)
          2'd1: data = {rt[31:24], m[31:8]};
          2'd2: data = {rt[31:16], m[31:16]};
          2'd3: data = {rt[31:8],  m[31:24]};
          default: data = m;
        endcase
      end
      default: data = m;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage feeding the register file,
// including a variable-latency load handshake on dm_data_ok.
//
// state | meaning
// IDLE  | no load outstanding; a load completing in its first WB cycle writes here
// WAIT  | load in WB, data not yet returned; stage is busy
// HAVE  | load data returned while held; writes repeat from the buffer
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [ADDR_WIDTH-1:0] mem_write_reg,
  input  logic [WIDTH-1:0]      mem_result,
  input  logic [2:0]            mem_load_type,
  input  logic [WIDTH-1:0]      mem_rt_data,
  input  logic [WIDTH-1:0]      dm_rdata,
  input  logic                  dm_data_ok,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] Write_register,
  output logic [WIDTH-1:0]      Write_data,
  output logic                  wb_valid,
  output logic                  wb_busy
);

  logic                  wb_reg_write;
  logic [ADDR_WIDTH-1:0] wb_write_reg;
  logic [WIDTH-1:0]      wb_result;
  load_type_e            wb_load_type;
  logic [WIDTH-1:0]      wb_rt_data;

  wb_state_e        state_q, state_d;
  logic [WIDTH-1:0] load_buf;
  logic             buf_en;
  logic             is_load;
  logic             load_present;
  logic             advance;
  logic             load_ready;
  logic [WIDTH-1:0] load_src;
  logic [WIDTH-1:0] load_data;

  // Once an instruction is in WB it is past commit, so busy overrides flush/stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_write_reg <= '0;
      wb_result    <= '0;
      wb_load_type <= LOAD_NONE;
      wb_rt_data   <= '0;
    end else if (!wb_busy) begin
      if (flush) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
        wb_load_type <= LOAD_NONE;
      end else if (!stall) begin
        wb_valid     <= mem_valid;
        wb_reg_write <= mem_reg_write;
        wb_write_reg <= mem_write_reg;
        wb_result    <= mem_result;
        wb_load_type <= load_type_e'(mem_load_type);
        wb_rt_data   <= mem_rt_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      load_buf <= '0;
    end else begin
      state_q <= state_d;
      if (buf_en) load_buf <= dm_rdata;
    end
  end

  assign is_load      = (wb_load_type != LOAD_NONE);
  assign load_present = wb_valid & is_load;
  assign advance      = flush | ~stall;

  always_comb begin
    state_d = state_q;
    buf_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_present) begin
          if (dm_data_ok) begin
            buf_en = 1'b1;
            if (!advance) state_d = HAVE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dm_data_ok) begin
          buf_en  = 1'b1;
          state_d = advance ? IDLE : HAVE;
        end
      end
      HAVE: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_busy    = load_present & (state_q != HAVE) & ~dm_data_ok;
  assign load_ready = (state_q == HAVE) | dm_data_ok;
  assign load_src   = (state_q == HAVE) ? load_buf : dm_rdata;

  load_formatter u_fmt (
    .load_type (wb_load_type),
    .off       (wb_result[1:0]),
    .m         (load_src),
    .rt        (wb_rt_data),
    .data      (load_data)
  );

  assign Write_register = wb_write_reg;
  assign Write_data     = is_load ? load_data : wb_result;
  assign RegWrite       = wb_valid & wb_reg_write & (wb_write_reg != '0)
                        & (~is_load | load_ready);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed + randomized self-checking bench for mem_wb_stage against a
// byte-arithmetic reference of the load formatting rules.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_write_reg;
  logic [31:0] mem_result;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_rt_data;
  logic [31:0] dm_rdata;
  logic        dm_data_ok;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        wb_valid;
  logic        wb_busy;

  int vectors;
  int miscompares;

  mem_wb_stage #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_write_reg  (mem_write_reg),
    .mem_result     (mem_result),
    .mem_load_type  (mem_load_type),
    .mem_rt_data    (mem_rt_data),
    .dm_rdata       (dm_rdata),
    .dm_data_ok     (dm_data_ok),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data),
    .wb_valid       (wb_valid),
    .wb_busy        (wb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: loads expressed as shifts and masks over the little-endian word.
  function automatic logic [31:0] ref_fmt(input logic [2:0] lt, input logic [1:0] off,
                                          input logic [31:0] m, input logic [31:0] rt);
    logic [31:0] b, h, lowmask, highmask;
    int k;
    k = int'(off);
    b = (m >> (8 * k)) & 32'hFF;
    h = (m >> (16 * int'(off[1]))) & 32'hFFFF;
    lowmask  = (32'h1 << (8 * (3 - k))) - 32'h1;
    highmask = ~(32'hFFFF_FFFF >> (8 * k));
    case (lt)
      3'd1: return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd2: return b;
      3'd3: return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4: return h;
      3'd6: return (m << (8 * (3 - k))) | (rt & lowmask);
      3'd7: return (m >> (8 * k)) | (rt & highmask);
      default: return m;
    endcase
  endfunction

  task automatic bubble_inputs();
    mem_valid     = 1'b0;
    mem_reg_write = 1'b0;
    mem_load_type = 3'd0;
  endtask

  // One load: capture, `delay` cycles without data, completion, then `hold` stalled cycles.
  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] off,
                         input logic [4:0] rd, input logic [31:0] rt, input logic [31:0] m,
                         input int delay, input int hold, input bit flush_wait);
    logic [31:0] exp;
    logic [31:0] res;
    exp = ref_fmt(lt, off, m, rt);
    res = $urandom;
    res[1:0] = off;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_write_reg = rd;
    mem_result = res; mem_load_type = lt; mem_rt_data = rt;
    dm_data_ok = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    bubble_inputs();
    for (int i = 0; i < delay; i++) begin
      dm_rdata = $urandom;
      flush = flush_wait;
      #1;
      chk({tag, ":wait_busy"}, 32'(wb_busy), 32'd1);
      chk({tag, ":wait_regwrite"}, 32'(RegWrite), 32'd0);
      if (flush_wait) chk({tag, ":wait_valid"}, 32'(wb_valid), 32'd1);
      tick();
    end
    flush = 1'b0;
    dm_data_ok = 1'b1;
    dm_rdata = m;
    stall = (hold > 0);
    #1;
    chk({tag, ":done_regwrite"}, 32'(RegWrite), 32'(rd != 5'd0));
    chk({tag, ":done_data"}, Write_data, exp);
    chk({tag, ":done_busy"}, 32'(wb_busy), 32'd0);
    chk({tag, ":done_reg"}, 32'(Write_register), 32'(rd));
    tick();
    dm_data_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      dm_rdata = $urandom;
      stall = (i != hold - 1);
      #1;
      chk({tag, ":have_regwrite"}, 32'(RegWrite), 32'(rd != 5'd0));
      chk({tag, ":have_data"}, Write_data, exp);
      chk({tag, ":have_busy"}, 32'(wb_busy), 32'd0);
      tick();
    end
    stall = 1'b0;
    chk({tag, ":after_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, ":after_regwrite"}, 32'(RegWrite), 32'd0);
  endtask

  initial begin
    logic [31:0] a_data, b_data;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_write_reg = 5'd0;
    mem_result = 32'd0; mem_load_type = 3'd0; mem_rt_data = 32'd0;
    dm_rdata = 32'd0; dm_data_ok = 1'b0;
    #12;
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_reg", 32'(Write_register), 32'd0);
    chk("rst_data", Write_data, 32'd0);
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_busy", 32'(wb_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU write, zero latency from capture
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_write_reg = 5'd5; mem_result = 32'h1234_5678;
    tick();
    bubble_inputs();
    #1;
    chk("alu_regwrite", 32'(RegWrite), 32'd1);
    chk("alu_reg", 32'(Write_register), 32'd5);
    chk("alu_data", Write_data, 32'h1234_5678);
    chk("alu_busy", 32'(wb_busy), 32'd0);
    tick();

    // stall holds, flush bubbles, then the held MEM instruction is captured
    a_data = $urandom; b_data = $urandom;
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_write_reg = 5'd7; mem_result = a_data;
    tick();
    mem_write_reg = 5'd9; mem_result = b_data; stall = 1'b1;
    tick();
    chk("stall_data", Write_data, a_data);
    chk("stall_reg", 32'(Write_register), 32'd7);
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_regwrite", 32'(RegWrite), 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    chk("resume_data", Write_data, b_data);
    chk("resume_regwrite", 32'(RegWrite), 32'd1);
    bubble_inputs();
    tick();

    // ALU write to $0
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_write_reg = 5'd0; mem_result = 32'h55;
    tick();
    bubble_inputs();
    #1;
    chk("alu_r0_regwrite", 32'(RegWrite), 32'd0);
    tick();

    do_load("lb",  3'd1, 2'd2, 5'd3, 32'h0, 32'h0080_FF00, 0, 0, 1'b0);
    chk("lb_const", ref_fmt(3'd1, 2'd2, 32'h0080_FF00, 32'h0), 32'hFFFF_FF80);
    do_load("lbu", 3'd2, 2'd2, 5'd3, 32'h0, 32'h0080_FF00, 0, 0, 1'b0);
    do_load("lh",  3'd3, 2'd2, 5'd3, 32'h0, 32'h0080_FF00, 0, 0, 1'b0);
    do_load("lwl", 3'd6, 2'd1, 5'd4, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 1'b0);
    do_load("lwr", 3'd7, 2'd1, 5'd4, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 1'b0);
    do_load("lw_delay", 3'd5, 2'd0, 5'd8, 32'h0, 32'hCAFE_F00D, 3, 0, 1'b1);
    do_load("have_wait", 3'd5, 2'd0, 5'd9, 32'h0, 32'hDEAD_BEEF, 1, 3, 1'b0);
    do_load("have_idle", 3'd1, 2'd3, 5'd10, 32'h0, 32'h8123_4567, 0, 2, 1'b0);
    do_load("load_r0", 3'd5, 2'd0, 5'd0, 32'h0, 32'h1111_2222, 2, 1, 1'b0);

    // asynchronous reset mid-WAIT, then a stray dm_data_ok
    mem_valid = 1'b1; mem_reg_write = 1'b1; mem_write_reg = 5'd6;
    mem_result = 32'h100; mem_load_type = 3'd5;
    tick();
    bubble_inputs();
    #1;
    chk("rstw_busy_before", 32'(wb_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_regwrite", 32'(RegWrite), 32'd0);
    chk("rstw_valid", 32'(wb_valid), 32'd0);
    chk("rstw_busy", 32'(wb_busy), 32'd0);
    chk("rstw_data", Write_data, 32'd0);
    chk("rstw_reg", 32'(Write_register), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    dm_data_ok = 1'b1; dm_rdata = $urandom;
    #1;
    chk("stray_regwrite", 32'(RegWrite), 32'd0);
    chk("stray_busy", 32'(wb_busy), 32'd0);
    tick();
    dm_data_ok = 1'b0;
    #1;
    chk("stray_idle_busy", 32'(wb_busy), 32'd0);
    tick();

    // randomized loads
    for (int n = 0; n < 40; n++) begin
      logic [2:0] lt;
      lt = 3'($urandom_range(1, 7));
      do_load("rand", lt, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
